// File: rtl/lsu.sv
// Load/store unit in front of a synchronous word memory with no byte enables.
// Sub-word stores are read-modify-write; each request returns one response pulse.
module lsu #(
   parameter int unsigned MEM_SIZE = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rd_data
);

   typedef enum logic [2:0] {StIdle, StRd, StMrg, StWr, StRsp} state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata;
   logic [31:0] r_addr;
   logic [31:0] r_wr_data;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_err;
   logic [31:0] w_idx;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;
   logic [31:0] w_merged;

   assign w_accept = req_valid && (r_state == StIdle);
   assign w_idx    = {2'b00, req_addr[31:2]};

   always_comb begin
      w_err = 1'b0;
      unique case (req_size)
         2'b00:   w_err = 1'b0;
         2'b01:   w_err = req_addr[0];
         2'b10:   w_err = (req_addr[1:0] != 2'b00);
         default: w_err = 1'b1;
      endcase
      if (w_idx >= MEM_SIZE) w_err = 1'b1;
   end

   assign w_byte = mem_rd_data[{r_lane, 3'b000} +: 8];
   assign w_half = r_lane[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

   // Load extension and store merge both work on the word read back in MRG.
   always_comb begin
      w_ext    = mem_rd_data;
      w_merged = mem_rd_data;
      if (r_size == 2'b00) begin
         w_ext = {{24{w_byte[7] & ~r_uns}}, w_byte};
         w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end else if (r_size == 2'b01) begin
         w_ext = {{16{w_half[15] & ~r_uns}}, w_half};
         if (r_lane[1]) w_merged[31:16] = r_wdata;
         else           w_merged[15:0]  = r_wdata;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (req_valid) begin
               if (w_err)                             w_state_nxt = StRsp;
               else if (req_we && req_size == 2'b10)  w_state_nxt = StWr;
               else                                   w_state_nxt = StRd;
            end
         end
         StRd:    w_state_nxt = StMrg;
         StMrg:   w_state_nxt = r_we ? StWr : StRsp;
         StWr:    w_state_nxt = StRsp;
         StRsp:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_we      <= 1'b0;
         r_size    <= 2'b00;
         r_uns     <= 1'b0;
         r_lane    <= 2'b00;
         r_wdata   <= 16'd0;
         r_addr    <= 32'd0;
         r_wr_data <= 32'd0;
         r_rdata   <= 32'd0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_lane  <= req_addr[1:0];
            r_wdata <= req_wdata[15:0];
            r_err   <= w_err;
            r_rdata <= 32'd0;
            if (!w_err) r_addr <= w_idx;
            if (!w_err && req_we && req_size == 2'b10) r_wr_data <= req_wdata;
         end
         if (r_state == StMrg) begin
            if (r_we) r_wr_data <= w_merged;
            else      r_rdata   <= w_ext;
         end
      end
   end

   assign req_ready   = (r_state == StIdle);
   assign rsp_valid   = (r_state == StRsp);
   assign rsp_rdata   = r_rdata;
   assign rsp_err     = r_err;
   assign mem_addr    = r_addr;
   assign mem_wr_data = r_wr_data;
   assign mem_we      = (r_state == StWr);
   assign mem_re      = (r_state == StRd);

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a word memory stand-in, a per-cycle reference checker and
// directed requests with hand-computed results.
module tb_lsu;

   localparam int unsigned MemSize = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rd_data = 32'd0;

   lsu #(.MEM_SIZE(MemSize)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_addr     (mem_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_rd_data  (mem_rd_data)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory stand-in: registered read data, valid the cycle after mem_re.
   logic [31:0] mem_arr [MemSize];
   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wr_data;
      if (mem_re) mem_rd_data <= mem_arr[mem_addr[7:0]];
   end

   // Reference model: architectural memory contents plus per-request timeline.
   logic [31:0] ref_mem [MemSize];

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic uns, input logic [1:0] a);
      logic [31:0] v;
      v = w >> (8 * a);
      if (sz == 2'b00) begin
         v = v & 32'hFF;
         if (!uns && v >= 32'h80) v = v - 32'h100;
      end else if (sz == 2'b01) begin
         v = v & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] a, input logic [31:0] wd);
      logic [31:0] mask;
      int          sh;
      mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
      sh   = (sz == 2'b00) ? 8 * a : 16 * a[1];
      return (w & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   bit          act = 0;
   int          k = 0;
   int          t_re, t_we, t_rsp;
   logic [31:0] e_idx, e_wd, e_rd;
   logic        e_err;
   int          n_we_pulses = 0;
   int          n_rsp_pulses = 0;

   always @(negedge clk) begin
      n_we_pulses  += int'(mem_we);
      n_rsp_pulses += int'(rsp_valid);
      if (!rst_n) begin
         act = 0;
      end else begin
         if (act) k++;
         chk("req_ready", {31'd0, req_ready}, {31'd0, !act});
         chk("mem_re", {31'd0, mem_re}, {31'd0, act && k == t_re});
         chk("mem_we", {31'd0, mem_we}, {31'd0, act && k == t_we});
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, act && k == t_rsp});
         if (act && k == t_re) chk("mem_addr_rd", mem_addr, e_idx);
         if (act && k == t_we) begin
            chk("mem_addr_wr", mem_addr, e_idx);
            chk("mem_wr_data", mem_wr_data, e_wd);
            ref_mem[e_idx[7:0]] = e_wd;
         end
         if (act && k == t_rsp) begin
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
            chk("rsp_rdata", rsp_rdata, e_rd);
            act = 0;
         end
         if (!act && req_valid && req_ready) begin
            act   = 1;
            k     = 0;
            e_idx = {2'b00, req_addr[31:2]};
            e_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (e_idx >= MemSize);
            e_rd  = 32'd0;
            e_wd  = 32'd0;
            if (e_err) begin
               t_re = 0; t_we = 0; t_rsp = 1;
            end else if (req_we && req_size == 2'b10) begin
               t_re = 0; t_we = 1; t_rsp = 2;
               e_wd = req_wdata;
            end else if (!req_we) begin
               t_re = 1; t_we = 0; t_rsp = 3;
               e_rd = model_load(ref_mem[e_idx[7:0]], req_size, req_unsigned, req_addr[1:0]);
            end else begin
               t_re = 1; t_we = 3; t_rsp = 4;
               e_wd = model_merge(ref_mem[e_idx[7:0]], req_size, req_addr[1:0], req_wdata);
            end
         end
      end
   end

   int          c_re, c_we, c_rsp;
   logic [31:0] c_wd, c_addr, c_rdata;
   logic        c_err;

   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
      int kk;
      bit got;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      kk = 0; got = 0; c_re = 0; c_we = 0; c_rsp = 0;
      c_wd = 32'd0; c_addr = 32'd0; c_rdata = 32'd0; c_err = 1'b0;
      while (!got && kk < 10) begin
         @(negedge clk);
         kk++;
         if (mem_re) c_re = kk;
         if (mem_we) begin c_we = kk; c_wd = mem_wr_data; c_addr = mem_addr; end
         if (rsp_valid) begin c_rsp = kk; c_rdata = rsp_rdata; c_err = rsp_err; got = 1; end
      end
      if (!got) chk("rsp_timeout", 32'd0, 32'd1);
      #1 req_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int we_before, rsp_before;
      for (int i = 0; i < int'(MemSize); i++) begin
         mem_arr[i] <= 32'd0;
         ref_mem[i] = 32'd0;
      end
      #23;
      chk_reset_vals("por");
      @(posedge clk); #3 rst_n = 1'b1;

      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
      chk("sw_we_cycle", c_we, 1);
      chk("sw_addr", c_addr, 32'd4);
      chk("sw_rsp_cycle", c_rsp, 2);
      chk("sw_err", {31'd0, c_err}, 32'd0);
      chk("sw_no_re", c_re, 0);

      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1);
      chk("lw_re_cycle", c_re, 1);
      chk("lw_rsp_cycle", c_rsp, 3);
      chk("lw_data", c_rdata, 32'hDEADBEEF);

      do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000005A, 0);
      chk("sb_re_cycle", c_re, 1);
      chk("sb_we_cycle", c_we, 3);
      chk("sb_wdata", c_wd, 32'hDE5ABEEF);
      chk("sb_rsp_cycle", c_rsp, 4);

      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 0);
      chk("lb_s", c_rdata, 32'hFFFFFFDE);
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 0);
      chk("lb_u", c_rdata, 32'h000000DE);
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 0);
      chk("lh_s", c_rdata, 32'hFFFFDE5A);
      do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 0);
      chk("lh_u", c_rdata, 32'h0000BEEF);

      do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234, 0);
      chk("sh_wdata", c_wd, 32'h12340000);
      do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 0);
      chk("lw_after_sh", c_rdata, 32'h12340000);

      do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'd0, 0);
      chk("err_lw_mis_err", {31'd0, c_err}, 32'd1);
      chk("err_lw_mis_rsp", c_rsp, 1);
      chk("err_lw_mis_mem", c_re + c_we, 0);
      do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h1111, 0);
      chk("err_sh_mis_err", {31'd0, c_err}, 32'd1);
      chk("err_sh_mis_rsp", c_rsp, 1);
      chk("err_sh_mis_mem", c_re + c_we, 0);
      do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 0);
      chk("err_size_err", {31'd0, c_err}, 32'd1);
      chk("err_size_rdata", c_rdata, 32'd0);
      chk("err_size_mem", c_re + c_we, 0);
      do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'd0, 0);
      chk("err_oob_err", {31'd0, c_err}, 32'd1);
      chk("err_oob_rsp", c_rsp, 1);
      chk("err_oob_mem", c_re + c_we, 0);

      // Abort a byte store while it sits in MRG.
      we_before  = n_we_pulses;
      rsp_before = n_rsp_pulses;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11;
      req_wdata = 32'h99;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1 chk_reset_vals("mid");
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_ready_after", {31'd0, req_ready}, 32'd1);
      chk("mid_no_we", n_we_pulses, we_before);
      chk("mid_no_rsp", n_rsp_pulses, rsp_before);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);
      chk("mid_word_intact", c_rdata, 32'hDE5ABEEF);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
